// File: rtl/alu_pkg.sv
// Shared aluC codes, FSM state and shift-kind types for the execute unit.
// The decode stage imports these codes so both ends agree.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_ADD1 = 4'b0001;
   localparam logic [3:0] ALU_SUB  = 4'b0010;
   localparam logic [3:0] ALU_AND  = 4'b0011;
   localparam logic [3:0] ALU_OR   = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_NOR  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b1001;
   localparam logic [3:0] ALU_SRL  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1011;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } alu_state_e;

   typedef enum logic [1:0] {
      SH_SLL = 2'b00,
      SH_SRL = 2'b01,
      SH_SRA = 2'b10
   } shift_kind_e;

   function automatic logic is_shift(input logic [3:0] code);
      return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
   endfunction

   // 1100..1111 are unassigned
   function automatic logic is_illegal(input logic [3:0] code);
      return code[3] & code[2];
   endfunction

   function automatic shift_kind_e shift_kind(input logic [3:0] code);
      shift_kind_e k;
      case (code)
         ALU_SRL: k = SH_SRL;
         ALU_SRA: k = SH_SRA;
         default: k = SH_SLL;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the issue stage, the execute unit and writeback.
interface alu_exec_unit_if #(parameter int WIDTH = 32);

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       aluC;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             ovf;
   logic             illegal;

   modport master (
      output in_valid, aluC, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, zero, carry, ovf, illegal
   );

   modport slave (
      input  in_valid, aluC, op_a, op_b, out_ready,
      output in_ready, out_valid, result, zero, carry, ovf, illegal
   );

endinterface

// File: rtl/alu_shifter.sv
// Shifter for the execute unit: one-bit step per call by default, full barrel
// shifter when ALU_BARREL_EN is defined.
module alu_shifter
   import alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data,
   input  logic [SHW-1:0]   amt,
   input  shift_kind_e      kind,
   output logic [WIDTH-1:0] shifted
);

`ifdef ALU_BARREL_EN
   always_comb begin
      case (kind)
         SH_SLL:  shifted = data << amt;
         SH_SRL:  shifted = data >> amt;
         default: shifted = $signed(data) >>> amt;
      endcase
   end
`else
   logic [WIDTH-1:0] step;

   // amt only gates the step: a zero count leaves the data untouched
   always_comb begin
      case (kind)
         SH_SLL:  step = {data[WIDTH-2:0], 1'b0};
         SH_SRL:  step = {1'b0, data[WIDTH-1:1]};
         default: step = {data[WIDTH-1], data[WIDTH-1:1]};
      endcase
      shifted = (amt != '0) ? step : data;
   end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute unit: single-cycle arith/logic, iterative shifts (barrel
// shifts with latency 1 when ALU_BARREL_EN is defined), valid/ready result.
//
// state   | meaning
// S_IDLE  | in_ready=1, waiting for a request
// S_SHIFT | iterative shift in progress, one bit per cycle
// S_DONE  | out_valid=1, result held until out_ready
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_exec_unit_if.slave   bus
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             illegal_q, illegal_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             alu_ovf;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] b_eff;
   logic             sub;
   logic [SHW-1:0]   amt_in;

   logic [WIDTH-1:0] sh_data;
   logic [SHW-1:0]   sh_amt;
   shift_kind_e      sh_kind;
   logic [WIDTH-1:0] sh_out;

   assign amt_in = bus.op_b[SHW-1:0];

`ifdef ALU_BARREL_EN
   assign sh_data = bus.op_a;
   assign sh_amt  = amt_in;
   assign sh_kind = shift_kind(bus.aluC);
`else
   logic [SHW-1:0] cnt_q, cnt_d;
   shift_kind_e    kind_q, kind_d;

   // the result register doubles as the shift register while iterating
   assign sh_data = result_q;
   assign sh_amt  = cnt_q;
   assign sh_kind = kind_q;
`endif

   alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .data    (sh_data),
      .amt     (sh_amt),
      .kind    (sh_kind),
      .shifted (sh_out)
   );

   always_comb begin
      sub       = (bus.aluC == ALU_SUB);
      b_eff     = sub ? ~bus.op_b : bus.op_b;
      sum       = {1'b0, bus.op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (bus.aluC)
         ALU_ADD, ALU_ADD1, ALU_SUB: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ovf   = (bus.op_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
         end
         ALU_AND:  alu_res = bus.op_a & bus.op_b;
         ALU_OR:   alu_res = bus.op_a | bus.op_b;
         ALU_XOR:  alu_res = bus.op_a ^ bus.op_b;
         ALU_NOR:  alu_res = ~(bus.op_a | bus.op_b);
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
`ifdef ALU_BARREL_EN
         ALU_SLL, ALU_SRL, ALU_SRA: alu_res = sh_out;
`else
         ALU_SLL, ALU_SRL, ALU_SRA: alu_res = bus.op_a;
`endif
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      result_d      = result_q;
      carry_d       = carry_q;
      ovf_d         = ovf_q;
      illegal_d     = illegal_q;
`ifndef ALU_BARREL_EN
      cnt_d         = cnt_q;
      kind_d        = kind_q;
`endif
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               result_d  = alu_res;
               carry_d   = alu_carry;
               ovf_d     = alu_ovf;
               illegal_d = is_illegal(bus.aluC);
               state_d   = S_DONE;
`ifndef ALU_BARREL_EN
               if (is_shift(bus.aluC) && (amt_in != '0)) begin
                  cnt_d   = amt_in;
                  kind_d  = shift_kind(bus.aluC);
                  state_d = S_SHIFT;
               end
`endif
            end
         end
`ifndef ALU_BARREL_EN
         S_SHIFT: begin
            result_d = sh_out;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == SHW'(1)) begin
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         result_q  <= '0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
`ifndef ALU_BARREL_EN
         cnt_q     <= '0;
         kind_q    <= SH_SLL;
`endif
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         carry_q   <= carry_d;
         ovf_q     <= ovf_d;
         illegal_q <= illegal_d;
`ifndef ALU_BARREL_EN
         cnt_q     <= cnt_d;
         kind_q    <= kind_d;
`endif
      end
   end

   assign bus.result  = result_q;
   assign bus.zero    = (result_q == '0);
   assign bus.carry   = carry_q;
   assign bus.ovf     = ovf_q;
   assign bus.illegal = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle integer execute unit of the single-issue datapath. Consumes the 4-bit ALU control code (`aluC`) produced by the decode stage together with two operands. Computes arithmetic/logic ops in one cycle and shifts iteratively, one bit per cycle. Results and flags are returned over a valid/ready handshake to the writeback stage.

## Interface
Parameters:
- `WIDTH`, 32 — operand/result width; power of two, ≥ 8.
- `SHW`, `$clog2(WIDTH)` — shift-amount width (local, derived).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `in_valid`  in  1  — operation request.
- `in_ready`  out  1  — unit can accept a request.
- `aluC`  in  4  — operation code.
- `op_a`  in  WIDTH  — operand A (shift source).
- `op_b`  in  WIDTH  — operand B; `op_b[SHW-1:0]` is the shift amount for shifts.
- `out_valid`  out  1  — result available.
- `out_ready`  in  1  — consumer takes result.
- `result`  out  WIDTH  — result.
- `zero`  out  1  — `result == 0`.
- `carry`  out  1  — ADD/SUB carry-out, 0 otherwise.
- `ovf`  out  1  — ADD/SUB signed overflow, 0 otherwise.
- `illegal`  out  1  — `aluC` was unassigned.

## Operation
- `aluC` codes:
  - 0000 and 0001: ADD.
  - 0010: SUB, computed as A + ~B + 1.
  - 0011: AND. 0100: OR. 0101: XOR. 0110: NOR.
  - 0111: SLT (signed, result 1/0). 1000: SLTU.
  - 1001: SLL. 1010: SRL. 1011: SRA.
  - 1100–1111: illegal. Result 0, `illegal`=1, flags 0, single-cycle latency.
- FSM states:
  - IDLE: `in_ready`=1.
  - SHIFT: iterating.
  - DONE: `out_valid`=1.
- IDLE → DONE on `in_valid` with a non-shift code, or with a shift code and amount 0. Result is registered on the accept edge.
- IDLE → SHIFT on `in_valid` with a shift code and amount k>0.
  - On entry, `op_a` is loaded into the shift register and k into a down-counter.
  - Each SHIFT cycle shifts one bit and decrements the counter. SRA replicates the MSB; SLL/SRL fill with 0.
  - SHIFT → DONE when the counter reaches 1, i.e. on the edge that performs the k-th shift.
- DONE → IDLE on `out_ready`. `result` and flags are held stable while `out_valid`=1 and `out_ready`=0.
- `in_ready`=0 in SHIFT and DONE. There is no result bypass; the next accept happens at the earliest in the cycle after DONE exits.
- Only the low SHW bits of `op_b` count for shifts; upper bits are ignored.
- `carry`/`ovf` are computed at full WIDTH. For SUB, `carry`=1 means no borrow.
- `zero` is derived from the registered `result`.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `zero`=1, `carry`=0, `ovf`=0, `illegal`=0, counter 0.
- Non-shift, or shift with k=0: accepted on edge N, `out_valid`=1 after edge N, latency 1.
- Shift by k≥1: `out_valid`=1 after edge N+k, latency k+1. Worst case is WIDTH cycles.
- `rst_n` asserted mid-shift or in DONE aborts the operation immediately. The pending result is discarded and never presented.
- `in_valid` while `in_ready`=0 is ignored. The producer must hold its request until accepted.

## Configuration
- `ALU_BARREL_EN` defined: shifts use a combinational barrel shifter. All codes take latency 1 and SHIFT state is never entered. The counter and shift register may be removed.
- `ALU_BARREL_EN` undefined: the iterative shifter described above.
- Results are bit-identical in both builds; only latency differs.

## Structure
- Shared package `alu_pkg` holds:
  - `aluC` code localparams (`ALU_ADD` … `ALU_SRA`).
  - FSM state typedef (IDLE/SHIFT/DONE).
  - The decode stage imports the same codes, so both ends agree.
- One sub-module, `alu_shifter`:
  - Single-step shifter in the iterative build, barrel shifter under `ALU_BARREL_EN`.
  - Ports: `data`, `amt`, `kind` (SLL/SRL/SRA) → `shifted`.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → `result`=0x80000000, `ovf`=1, `carry`=0, `zero`=0, `out_valid` one cycle after accept.
- SUB 5 − 5 → `result`=0, `zero`=1, `carry`=1. SLT A=0xFFFFFFFF, B=1 → 1. SLTU on the same operands → 0.
- SRA A=0x80000000 by 4 → 0xF8000000, `out_valid` 5 cycles after accept, `in_ready`=0 throughout. SLL A=1 by 0 → 1 with latency 1.
- Hold `out_ready`=0 for 3 cycles in DONE → `result` and flags stable. A new `in_valid` during this time is not accepted.
- Assert `rst_n` low during the 10th cycle of a 31-bit SRL → `out_valid`=0, `in_ready`=1, `result`=0, and no stale result after release.
- `aluC`=1110 → `illegal`=1, `result`=0, latency 1. Repeat all of the above with `ALU_BARREL_EN` and expect identical results at latency 1.
